// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter.
package mul_arb_pkg;

  // Upper bounds used to give the round-robin helper fixed-width arguments.
  localparam int MAX_CH  = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // Requester ID width; a single-bit ID is kept even for tiny channel counts.
  function automatic int id_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // First set bit of req at or above ptr, wrapping at ch-1 back to 0.
  // The scan runs from the largest offset down so the smallest offset is the
  // last one assigned, which avoids a loop break.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]  req,
                                       input logic [MAX_IDW-1:0] ptr,
                                       input int                 ch);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < ch) begin
        cand = int'(ptr) + k;
        if (cand >= ch) cand = cand - ch;
        if (req[4'(cand)]) begin
          res.found = 1'b1;
          res.idx   = MAX_IDW'(cand);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mul.sv
// Signed fixed-point multiplier with round-half-to-even at the binary point.
// A start pulse captures the operands' rounded product; done rises LAT cycles
// later for one cycle. ovf flags a product that does not fit in WIDTH bits.
// FBITS must be at least 1.
module mul #(
  parameter int WIDTH = 8,
  parameter int FBITS = 4,
  parameter int LAT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    done,
  output logic signed [WIDTH-1:0] val,
  output logic                    ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [FBITS-1:0] HALF = FBITS'(1) << (FBITS - 1);

  logic signed [PW-1:0]    prod;
  logic signed [PW:0]      q_floor;
  logic signed [PW:0]      q_rnd;
  logic [FBITS-1:0]        frac;
  logic                    round_up;
  logic                    fits;

  logic                    run;
  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] val_q;
  logic                    ovf_q;

  // Full-precision product, floor-shift, then round ties toward the even value.
  always_comb begin
    prod     = PW'(a) * PW'(b);
    q_floor  = (PW+1)'(prod >>> FBITS);
    frac     = prod[FBITS-1:0];
    round_up = (frac > HALF) || ((frac == HALF) && q_floor[0]);
    q_rnd    = q_floor + (PW+1)'({1'b0, round_up});
    fits     = (q_rnd[PW:WIDTH-1] == '0) || (q_rnd[PW:WIDTH-1] == '1);
  end

  // Capture the result on start, then count down to the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      run   <= 1'b0;
      cnt   <= '0;
      val_q <= '0;
      ovf_q <= 1'b0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= CW'(LAT - 1);
      val_q <= q_rnd[WIDTH-1:0];
      ovf_q <= !fits;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - CW'(1);
    end
  end

  assign done = run && (cnt == '0);
  assign val  = val_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier among CH requesters.
// Each product is returned tagged with the ID of the requester that asked.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | sample req; on any request latch winner's operands/ID, pulse ack
// ISSUE | drive mul start with the latched operands
// WAIT  | hold until mul done, then publish response and advance pointer
module mul_arbiter import mul_arb_pkg::*; #(
  parameter  int CH    = 4,
  parameter  int WIDTH = 8,
  parameter  int FBITS = 4,
  localparam int IDW   = id_width(CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         req,
  input  logic [CH*WIDTH-1:0]   req_a,
  input  logic [CH*WIDTH-1:0]   req_b,
  output logic [CH-1:0]         ack,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_val,
  output logic                  rsp_ovf
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;

  logic [1:0]              state;
  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          id_q;
  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;

  rr_pick_t                pick;
  logic [IDW-1:0]          win_id;
  logic [WIDTH-1:0]        win_a;
  logic [WIDTH-1:0]        win_b;

  logic                    mul_start;
  logic                    mul_done;
  logic signed [WIDTH-1:0] mul_val;
  logic                    mul_ovf;

  // Round-robin winner and its operand slices, evaluated every cycle.
  always_comb begin
    pick   = rr_pick(MAX_CH'(req), MAX_IDW'(ptr), CH);
    win_id = IDW'(pick.idx);
    win_a  = req_a[int'(win_id) * WIDTH +: WIDTH];
    win_b  = req_b[int'(win_id) * WIDTH +: WIDTH];
  end

  assign mul_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  // Arbitration FSM, operand capture and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ack       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_val   <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      ack       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick.found) begin
            id_q  <= win_id;
            a_q   <= win_a;
            b_q   <= win_b;
            ack   <= CH'(1) << win_id;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            rsp_val   <= mul_val;
            rsp_ovf   <= mul_ovf;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            // Just-served requester drops to lowest priority.
            ptr       <= (id_q == IDW'(CH - 1)) ? '0 : id_q + IDW'(1);
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  mul #(
    .WIDTH (WIDTH),
    .FBITS (FBITS)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a_q),
    .b     (b_q),
    .done  (mul_done),
    .val   (mul_val),
    .ovf   (mul_ovf)
  );

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed and randomized checks of mul_arbiter against a transaction-level model.
module tb_mul_arbiter;

  localparam int CH    = 4;
  localparam int WIDTH = 8;
  localparam int FBITS = 4;
  localparam int IDW   = (CH > 1) ? $clog2(CH) : 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH-1:0]       req;
  logic [CH*WIDTH-1:0] req_a;
  logic [CH*WIDTH-1:0] req_b;
  logic [CH-1:0]       ack;
  logic                busy;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [WIDTH-1:0]    rsp_val;
  logic                rsp_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  logic [WIDTH-1:0] op_a [CH];
  logic [WIDTH-1:0] op_b [CH];

  always #5 clk = ~clk;

  mul_arbiter #(.CH(CH), .WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .ack       (ack),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_val   (rsp_val),
    .rsp_ovf   (rsp_ovf)
  );

  // Operands of a pending, un-acked request must stay stable.
  logic [CH-1:0]       req_p = '0;
  logic [CH*WIDTH-1:0] a_p   = '0;
  logic [CH*WIDTH-1:0] b_p   = '0;
  logic                proto_bad = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++)
      if (req[i] && req_p[i] && !ack[i] &&
          ((req_a[i*WIDTH +: WIDTH] !== a_p[i*WIDTH +: WIDTH]) ||
           (req_b[i*WIDTH +: WIDTH] !== b_p[i*WIDTH +: WIDTH])))
        proto_bad <= 1'b1;
    req_p <= req;
    a_p   <= req_a;
    b_p   <= req_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < CH; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  endtask

  // Reference: exact product, scaled by 2^-FBITS, ties rounded to even.
  function automatic void model_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] v, output bit o);
    int sa, sb, p, q, r, half, lim;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    p    = sa * sb;
    q    = p >>> FBITS;
    r    = p - q * (1 << FBITS);
    half = 1 << (FBITS - 1);
    if (r > half || (r == half && (q % 2) != 0)) q = q + 1;
    lim  = 1 << (WIDTH - 1);
    o    = (q >= lim) || (q < -lim);
    v    = q[WIDTH-1:0];
  endfunction

  // Reference: first requester at or after the pointer, cyclically.
  function automatic int pick_model(input logic [CH-1:0] r, input int p);
    for (int k = 0; k < CH; k++)
      if (r[(p + k) % CH]) return (p + k) % CH;
    return -1;
  endfunction

  // One complete transaction from an IDLE cycle with req already driven.
  task automatic expect_op(input bit drop, input bit use_exp, input logic [WIDTH-1:0] d_val,
                           input bit d_ovf, input string tag);
    int               exp_id, cnt;
    logic [WIDTH-1:0] e_val;
    bit               e_ovf;
    exp_id = pick_model(req, ptr_m);
    if (exp_id < 0) exp_id = 0;
    if (use_exp) begin
      e_val = d_val;
      e_ovf = d_ovf;
    end else begin
      model_mul(op_a[exp_id], op_b[exp_id], e_val, e_ovf);
    end
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ack == '0 && cnt < 10);
    chk({tag, ".ack_lat"}, cnt, 1);
    chk({tag, ".ack"}, ack, 32'(1 << exp_id));
    chk({tag, ".busy_ack"}, busy, 1);
    if (drop) begin
      req[exp_id] = 1'b0;
    end else begin
      op_a[exp_id] = WIDTH'($urandom);
      op_b[exp_id] = WIDTH'($urandom);
      drive_ops();
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".early_rsp"}, rsp_valid, 0);
      chk({tag, ".no_ack"}, ack, 0);
    end
    tick();
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_id"}, rsp_id, exp_id);
    chk({tag, ".rsp_ovf"}, rsp_ovf, e_ovf);
    if (!e_ovf) chk({tag, ".rsp_val"}, rsp_val, e_val);
    chk({tag, ".busy_end"}, busy, 0);
    ptr_m = (exp_id + 1) % CH;
  endtask

  initial begin
    logic [CH-1:0] add;
    bit            any_out;
    int            sel;

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < CH; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    drive_ops();
    tick();
    tick();
    chk("reset.ack", ack, 0);
    chk("reset.busy", busy, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_id", rsp_id, 0);
    chk("reset.rsp_val", rsp_val, 0);
    chk("reset.rsp_ovf", rsp_ovf, 0);
    rst = 1'b0;
    ptr_m = 0;
    tick();

    // Single request, then signed/rounding cases, then overflow.
    op_a[1] = 8'h18; op_b[1] = 8'h20; req = 4'b0010; drive_ops();
    expect_op(1, 1, 8'h30, 0, "single");
    op_a[0] = 8'hE8; op_b[0] = 8'h20; req = 4'b0001; drive_ops();
    expect_op(1, 1, 8'hD0, 0, "neg");
    op_a[0] = 8'h01; op_b[0] = 8'h08; req = 4'b0001; drive_ops();
    expect_op(1, 1, 8'h00, 0, "tie_even");
    op_a[0] = 8'h03; op_b[0] = 8'h08; req = 4'b0001; drive_ops();
    expect_op(1, 1, 8'h02, 0, "tie_up");
    op_a[2] = 8'h40; op_b[2] = 8'h40; req = 4'b0100; drive_ops();
    expect_op(1, 1, 8'h00, 1, "ovf");

    // Reset while waiting on the multiplier discards the operation.
    op_a[2] = 8'h10; op_b[2] = 8'h10; req = 4'b0100; drive_ops();
    tick();
    chk("rst_mid.ack", ack, 4'b0100);
    req = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid.ack0", ack, 0);
    chk("rst_mid.busy0", busy, 0);
    chk("rst_mid.valid0", rsp_valid, 0);
    chk("rst_mid.id0", rsp_id, 0);
    chk("rst_mid.val0", rsp_val, 0);
    chk("rst_mid.ovf0", rsp_ovf, 0);
    any_out = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid !== 1'b0 || ack !== '0) any_out = 1'b1;
    end
    chk("rst_mid.quiet", any_out, 0);
    ptr_m = 0;
    op_a[2] = 8'h20; op_b[2] = 8'h28;
    op_a[3] = 8'h14; op_b[3] = 8'hF0;
    req = 4'b1100; drive_ops();
    expect_op(1, 0, 8'h00, 0, "post_rst_ptr");
    expect_op(1, 0, 8'h00, 0, "post_rst_req3");

    // Fairness with everyone requesting from reset, then two requesters.
    rst = 1'b1;
    for (int i = 0; i < CH; i++) begin
      op_a[i] = WIDTH'($urandom);
      op_b[i] = WIDTH'($urandom);
    end
    req = 4'b1111; drive_ops();
    tick();
    tick();
    rst = 1'b0;
    ptr_m = 0;
    for (int n = 0; n < 5; n++) expect_op(0, 0, 8'h00, 0, "fair4");
    req = 4'b0101;
    for (int n = 0; n < 4; n++) expect_op(0, 0, 8'h00, 0, "fair2");

    // Random request sets, operands, and drop/hold after ack.
    for (int it = 0; it < 40; it++) begin
      add = CH'($urandom);
      for (int i = 0; i < CH; i++)
        if (add[i] && !req[i]) begin
          req[i]  = 1'b1;
          op_a[i] = WIDTH'($urandom);
          op_b[i] = WIDTH'($urandom);
        end
      if (req == '0) begin
        sel       = $urandom_range(0, CH - 1);
        req[sel]  = 1'b1;
        op_a[sel] = WIDTH'($urandom);
        op_b[sel] = WIDTH'($urandom);
      end
      drive_ops();
      expect_op(1'($urandom_range(0, 1)), 0, 8'h00, 0, "rnd");
    end

    req = '0;
    tick();
    chk("protocol", proto_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
